// File: rtl/l2_line_responder_pkg.sv
// Shared width helpers and FSM encoding for the L2 line responder and its line store.
package l2_line_responder_pkg;

    function automatic int offset_width(input int data_width, input int block_size);
        return $clog2(data_width * block_size / 8);
    endfunction

    function automatic int line_addr_width(input int address_width, input int data_width,
                                           input int block_size);
        return address_width - offset_width(data_width, block_size);
    endfunction

    function automatic int cache_width(input int data_width, input int block_size);
        return data_width * block_size;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_DONE,
        RD_WAIT,
        RD_RESP
    } state_t;

endpackage

// File: rtl/l2_line_responder_if.sv
// L1 D-cache <-> L2 line interface; the cache is the master, the L2 responder the slave.
interface l2_line_responder_if
    import l2_line_responder_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 32
);
    localparam int LINE_AW = line_addr_width(address_width, data_width, block_size);
    localparam int CW      = cache_width(data_width, block_size);

    logic               ADDR_TO_L2_VALID;
    logic [LINE_AW-1:0] ADDR_TO_L2;
    logic [CW-1:0]      DATA_FROM_L2;
    logic               DATA_FROM_L2_VALID;
    logic               DATA_TO_L2_VALID;
    logic [CW-1:0]      DATA_TO_L2;
    logic [LINE_AW-1:0] WADDR_TO_L2;
    logic               WRITE_DONE;
    logic               PROTO_ERR;

    modport master (
        output ADDR_TO_L2_VALID, ADDR_TO_L2, DATA_TO_L2_VALID, DATA_TO_L2, WADDR_TO_L2,
        input  DATA_FROM_L2, DATA_FROM_L2_VALID, WRITE_DONE, PROTO_ERR
    );

    modport slave (
        input  ADDR_TO_L2_VALID, ADDR_TO_L2, DATA_TO_L2_VALID, DATA_TO_L2, WADDR_TO_L2,
        output DATA_FROM_L2, DATA_FROM_L2_VALID, WRITE_DONE, PROTO_ERR
    );

endinterface

// File: rtl/l2_line_responder_store.sv
// Line-wide RAM: synchronous write, registered read; contents survive reset.
module l2_line_store #(
    parameter int depth     = 1024,
    parameter int width     = 1024,
    parameter int idx_width = 10
) (
    input  logic                 CLK,
    input  logic                 wr_en,
    input  logic [idx_width-1:0] wr_idx,
    input  logic [width-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [idx_width-1:0] rd_idx,
    output logic [width-1:0]     rd_data
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/l2_line_responder.sv
// L2-side responder: edge-captured fill/writeback slots served one at a time by a latency FSM.
module l2_line_responder
    import l2_line_responder_pkg::*;
#(
    parameter int data_width    = 32,
    parameter int address_width = 32,
    parameter int block_size    = 32,
    parameter int mem_depth     = 1024,
    parameter int read_latency  = 4,
    parameter int write_latency = 4
) (
    input logic CLK,
    input logic RST,
    l2_line_responder_if.slave bus
);
    localparam int CW      = cache_width(data_width, block_size);
    localparam int IDX_W   = $clog2(mem_depth);
    localparam int MAX_LAT = (read_latency > write_latency) ? read_latency : write_latency;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             rd_valid_q, wr_valid_q;
    logic             rd_full, wr_full, proto_err;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [CW-1:0]    wr_line, store_q, dout;
    logic             rd_edge, wr_edge;
    logic             store_wr, store_rd, load_dout, rd_free, wr_free;

    assign rd_edge = bus.ADDR_TO_L2_VALID && !rd_valid_q;
    assign wr_edge = bus.DATA_TO_L2_VALID && !wr_valid_q;

    // A slot freeing this cycle accepts a new edge; an occupied slot drops it and flags PROTO_ERR.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_full    <= 1'b0;
            wr_full    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            rd_valid_q <= bus.ADDR_TO_L2_VALID;
            wr_valid_q <= bus.DATA_TO_L2_VALID;
            if (rd_edge) begin
                if (rd_full && !rd_free) begin
                    proto_err <= 1'b1;
                end else begin
                    rd_full <= 1'b1;
                    rd_idx  <= bus.ADDR_TO_L2[IDX_W-1:0];
                end
            end else if (rd_free) begin
                rd_full <= 1'b0;
            end
            if (wr_edge) begin
                if (wr_full && !wr_free) begin
                    proto_err <= 1'b1;
                end else begin
                    wr_full <= 1'b1;
                    wr_idx  <= bus.WADDR_TO_L2[IDX_W-1:0];
                    wr_line <= bus.DATA_TO_L2;
                end
            end else if (wr_free) begin
                wr_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_dout)
                dout <= store_q;
        end
    end

    // Writeback wins over a pending fill so a fill of a just-evicted line sees the new data.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        store_wr   = 1'b0;
        store_rd   = 1'b0;
        load_dout  = 1'b0;
        rd_free    = 1'b0;
        wr_free    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_full) begin
                    state_next = WR_WAIT;
                    cnt_next   = CNT_W'(write_latency - 1);
                end else if (rd_full) begin
                    state_next = RD_WAIT;
                    cnt_next   = CNT_W'(read_latency - 1);
                    store_rd   = 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    store_wr   = 1'b1;
                    state_next = WR_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WR_DONE: begin
                wr_free    = 1'b1;
                state_next = IDLE;
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    load_dout  = 1'b1;
                    state_next = RD_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RD_RESP: begin
                rd_free    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    l2_line_store #(
        .depth    (mem_depth),
        .width    (CW),
        .idx_width(IDX_W)
    ) u_store (
        .CLK    (CLK),
        .wr_en  (store_wr),
        .wr_idx (wr_idx),
        .wr_data(wr_line),
        .rd_en  (store_rd),
        .rd_idx (rd_idx),
        .rd_data(store_q)
    );

    assign bus.DATA_FROM_L2       = dout;
    assign bus.DATA_FROM_L2_VALID = rd_free;
    assign bus.WRITE_DONE         = wr_free;
    assign bus.PROTO_ERR          = proto_err;

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: vector table, corner sequences, random vs line model.
module tb_l2_line_responder;
    import l2_line_responder_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int BS    = 32;
    localparam int DEPTH = 1024;
    localparam int RL    = 4;
    localparam int WL    = 4;
    localparam int CW    = cache_width(DW, BS);
    localparam int LAW   = line_addr_width(AW, DW, BS);

    typedef logic [CW-1:0]  line_t;
    typedef logic [LAW-1:0] laddr_t;
    typedef struct {
        bit          is_wr;
        laddr_t      addr;
        int unsigned seed;
        int          hold;
        int unsigned exp_seed;
    } vec_t;

    logic CLK;
    logic RST;

    l2_line_responder_if #(.data_width(DW), .address_width(AW), .block_size(BS)) bus();

    l2_line_responder #(
        .data_width   (DW),
        .address_width(AW),
        .block_size   (BS),
        .mem_depth    (DEPTH),
        .read_latency (RL),
        .write_latency(WL)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int    checks;
    int    errors;
    int    cyc;
    int    rd_cyc_q[$];
    line_t rd_data_q[$];
    int    wr_cyc_q[$];
    line_t model_mem[int];
    int    written_q[$];
    vec_t  vecs[9];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Response log: edge number of every pulse, sampled just after the edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (bus.DATA_FROM_L2_VALID === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            rd_data_q.push_back(bus.DATA_FROM_L2);
        end
        if (bus.WRITE_DONE === 1'b1)
            wr_cyc_q.push_back(cyc);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    function automatic line_t make_line(input int unsigned seed);
        line_t l;
        for (int i = 0; i < BS; i++)
            l[i*DW +: DW] = (seed * 32'h0100_0193) ^ (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
        return l;
    endfunction

    task automatic checkOutput(input string name, input line_t actual, input line_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c)
            @(negedge CLK);
    endtask

    task automatic clear_log();
        rd_cyc_q.delete();
        rd_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic model_write(input laddr_t addr, input line_t line);
        int k;
        k = int'(addr) % DEPTH;
        if (!model_mem.exists(k))
            written_q.push_back(k);
        model_mem[k] = line;
    endtask

    // One isolated request; t returns the capture edge number.
    task automatic applyStimulus(input bit is_wr, input laddr_t addr, input line_t line,
                                 input int hold, output int t);
        @(negedge CLK);
        clear_log();
        t = cyc + 1;
        if (is_wr) begin
            bus.WADDR_TO_L2      = addr;
            bus.DATA_TO_L2       = line;
            bus.DATA_TO_L2_VALID = 1'b1;
        end else begin
            bus.ADDR_TO_L2       = addr;
            bus.ADDR_TO_L2_VALID = 1'b1;
        end
        repeat (hold) @(negedge CLK);
        bus.DATA_TO_L2_VALID = 1'b0;
        bus.ADDR_TO_L2_VALID = 1'b0;
        wait_until(t + (is_wr ? WL : RL) + 6);
        if (is_wr)
            model_write(addr, line);
    endtask

    task automatic checkTxn(input string name, input bit is_wr, input int t, input line_t exp_line);
        if (is_wr) begin
            checkOutput({name, " write_done count"}, line_t'(wr_cyc_q.size()), line_t'(1));
            checkOutput({name, " stray fill count"}, line_t'(rd_cyc_q.size()), line_t'(0));
            if (wr_cyc_q.size() > 0)
                checkOutput({name, " write latency"}, line_t'(wr_cyc_q[0] - t), line_t'(WL + 1));
        end else begin
            checkOutput({name, " fill count"}, line_t'(rd_cyc_q.size()), line_t'(1));
            checkOutput({name, " stray write_done count"}, line_t'(wr_cyc_q.size()), line_t'(0));
            if (rd_cyc_q.size() > 0) begin
                checkOutput({name, " fill latency"}, line_t'(rd_cyc_q[0] - t), line_t'(RL + 1));
                checkOutput({name, " fill data"}, rd_data_q[0], exp_line);
            end
        end
    endtask

    initial begin
        int t;
        line_t line_a, line_c;

        RST                  = 1'b1;
        bus.ADDR_TO_L2_VALID = 1'b0;
        bus.ADDR_TO_L2       = '0;
        bus.DATA_TO_L2_VALID = 1'b0;
        bus.DATA_TO_L2       = '0;
        bus.WADDR_TO_L2      = '0;
        repeat (3) @(negedge CLK);
        checkOutput("reset DATA_FROM_L2", bus.DATA_FROM_L2, '0);
        checkOutput("reset DATA_FROM_L2_VALID", line_t'(bus.DATA_FROM_L2_VALID), '0);
        checkOutput("reset WRITE_DONE", line_t'(bus.WRITE_DONE), '0);
        checkOutput("reset PROTO_ERR", line_t'(bus.PROTO_ERR), '0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Single transactions: preload/fill, held writeback, aliasing, top and bottom index.
        vecs[0] = '{1'b1, 25'h000_0010, 11, 1, 0};
        vecs[1] = '{1'b0, 25'h000_0010, 0,  1, 11};
        vecs[2] = '{1'b1, 25'h000_0022, 22, 3, 0};
        vecs[3] = '{1'b0, 25'h000_0022, 0,  1, 22};
        vecs[4] = '{1'b0, 25'h000_0410, 0,  2, 11};
        vecs[5] = '{1'b1, 25'h000_03FF, 55, 2, 0};
        vecs[6] = '{1'b0, 25'h000_07FF, 0,  1, 55};
        vecs[7] = '{1'b1, 25'h000_0000, 77, 1, 0};
        vecs[8] = '{1'b0, 25'h1FF_FC00, 0,  3, 77};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].is_wr, vecs[i].addr, make_line(vecs[i].seed), vecs[i].hold, t);
            checkTxn($sformatf("vec%0d", i), vecs[i].is_wr, t, make_line(vecs[i].exp_seed));
        end

        // Writeback and fill of the same line rising together: write first, one idle cycle, then fill.
        line_c = make_line(33);
        @(negedge CLK);
        clear_log();
        t                    = cyc + 1;
        bus.WADDR_TO_L2      = 25'h30;
        bus.DATA_TO_L2       = line_c;
        bus.ADDR_TO_L2       = 25'h30;
        bus.DATA_TO_L2_VALID = 1'b1;
        bus.ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        bus.DATA_TO_L2_VALID = 1'b0;
        bus.ADDR_TO_L2_VALID = 1'b0;
        wait_until(t + WL + RL + 9);
        model_write(25'h30, line_c);
        checkOutput("same-cycle write_done count", line_t'(wr_cyc_q.size()), line_t'(1));
        checkOutput("same-cycle fill count", line_t'(rd_cyc_q.size()), line_t'(1));
        if (wr_cyc_q.size() > 0)
            checkOutput("same-cycle write latency", line_t'(wr_cyc_q[0] - t), line_t'(WL + 1));
        if (rd_cyc_q.size() > 0) begin
            checkOutput("same-cycle fill latency", line_t'(rd_cyc_q[0] - t), line_t'((WL + 1) + 1 + (RL + 1)));
            checkOutput("same-cycle fill data", rd_data_q[0], line_c);
        end

        // Random traffic against the line model; fills only target lines already written.
        for (int n = 0; n < 40; n++) begin
            bit     is_wr;
            int     idx;
            laddr_t a;
            line_t  l;
            is_wr = (written_q.size() == 0) || ($urandom_range(0, 1) == 1);
            if (is_wr)
                idx = int'($urandom_range(0, DEPTH - 1));
            else
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
            a = laddr_t'(($urandom % 32768) * DEPTH + idx);
            l = make_line($urandom);
            applyStimulus(is_wr, a, l, int'($urandom_range(1, 3)), t);
            checkTxn($sformatf("rand%0d", n), is_wr, t, is_wr ? l : model_mem[idx]);
        end
        checkOutput("PROTO_ERR clear after clean traffic", line_t'(bus.PROTO_ERR), '0);

        // Fill A in flight; B edge while slot occupied is dropped; C edge in the freeing cycle is taken.
        line_a = model_mem[32'h22];
        line_c = model_mem[32'h3FF];
        @(negedge CLK);
        clear_log();
        t                    = cyc + 1;
        bus.ADDR_TO_L2       = 25'h22;
        bus.ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        bus.ADDR_TO_L2_VALID = 1'b0;
        wait_until(t + 2);
        checkOutput("slot-full PROTO_ERR before drop", line_t'(bus.PROTO_ERR), '0);
        bus.ADDR_TO_L2       = 25'h10;
        bus.ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        bus.ADDR_TO_L2_VALID = 1'b0;
        checkOutput("slot-full PROTO_ERR after drop", line_t'(bus.PROTO_ERR), line_t'(1));
        wait_until(t + RL + 1);
        bus.ADDR_TO_L2       = 25'h3FF;
        bus.ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        bus.ADDR_TO_L2_VALID = 1'b0;
        wait_until(t + 2 * RL + 9);
        checkOutput("slot-full fill count", line_t'(rd_cyc_q.size()), line_t'(2));
        if (rd_cyc_q.size() == 2) begin
            checkOutput("slot-full first latency", line_t'(rd_cyc_q[0] - t), line_t'(RL + 1));
            checkOutput("slot-full first data", rd_data_q[0], line_a);
            checkOutput("slot-full second latency", line_t'(rd_cyc_q[1] - t), line_t'((RL + 2) + (RL + 1)));
            checkOutput("slot-full second data", rd_data_q[1], line_c);
        end
        checkOutput("PROTO_ERR sticky", line_t'(bus.PROTO_ERR), line_t'(1));

        // Reset during RD_WAIT: response is lost, outputs clear, store keeps its lines.
        @(negedge CLK);
        clear_log();
        t                    = cyc + 1;
        bus.ADDR_TO_L2       = 25'h30;
        bus.ADDR_TO_L2_VALID = 1'b1;
        @(negedge CLK);
        bus.ADDR_TO_L2_VALID = 1'b0;
        wait_until(t + 2);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("mid-reset DATA_FROM_L2", bus.DATA_FROM_L2, '0);
        checkOutput("mid-reset DATA_FROM_L2_VALID", line_t'(bus.DATA_FROM_L2_VALID), '0);
        checkOutput("mid-reset WRITE_DONE", line_t'(bus.WRITE_DONE), '0);
        checkOutput("mid-reset PROTO_ERR", line_t'(bus.PROTO_ERR), '0);
        RST = 1'b0;
        wait_until(t + RL + 8);
        checkOutput("mid-reset lost fill count", line_t'(rd_cyc_q.size()), line_t'(0));
        applyStimulus(1'b0, 25'h30, '0, 1, t);
        checkTxn("refetch after reset", 1'b0, t, model_mem[32'h30]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
